// File: rtl/kalman_scheduler_if.sv
// Request/status bundle between the sensor front end and the Kalman scheduler.
//   master : requester side; drives clear, rp_req, yaw_req and observes status.
//   slave  : scheduler side; samples the requests and drives the datapath
//            strobe, axis select, busy, count_out, done pulses and overrun.
interface kalman_scheduler_if #(
   parameter int CNT_BITS = 6
);
   logic                clear;
   logic                rp_req;
   logic                yaw_req;
   logic                dp_start;
   logic                dp_sel;
   logic                busy;
   logic [CNT_BITS-1:0] count_out;
   logic                rp_done;
   logic                yaw_done;
   logic [1:0]          overrun;

   modport master (
      output clear, rp_req, yaw_req,
      input  dp_start, dp_sel, busy, count_out, rp_done, yaw_done, overrun
   );

   modport slave (
      input  clear, rp_req, yaw_req,
      output dp_start, dp_sel, busy, count_out, rp_done, yaw_done, overrun
   );
endinterface

// File: rtl/kalman_scheduler.sv
// Time-shares the single Kalman datapath between roll/pitch and yaw updates.
// Requests are queued as pending bits, granted round-robin, and each run is
// timed for a fixed per-axis cycle budget before a one-cycle done pulse.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, overrides everything
//   bus  : kalman_scheduler_if.slave (clear, requests in; strobe, select,
//          busy, count_out, done pulses, sticky overrun out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no run active; grants a pending axis if any
// S_RUN  | datapath owned by dp_sel; count_out walks 1..N
module kalman_scheduler #(
   parameter int CNT_BITS   = 6,
   parameter int RP_CYCLES  = 63,
   parameter int YAW_CYCLES = 63
) (
   input logic               clk,
   input logic               rst,
   kalman_scheduler_if.slave bus
);
   localparam int MAX_N = (1 << CNT_BITS) - 1;

   generate
      if (RP_CYCLES < 1 || RP_CYCLES > MAX_N) begin : g_bad_rp
         $error("kalman_scheduler: RP_CYCLES out of range 1..2^CNT_BITS-1");
      end
      if (YAW_CYCLES < 1 || YAW_CYCLES > MAX_N) begin : g_bad_yaw
         $error("kalman_scheduler: YAW_CYCLES out of range 1..2^CNT_BITS-1");
      end
   endgenerate

   localparam logic [CNT_BITS-1:0] RP_N  = CNT_BITS'(RP_CYCLES);
   localparam logic [CNT_BITS-1:0] YAW_N = CNT_BITS'(YAW_CYCLES);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [1:0]          pend_q, pend_d;
   logic [1:0]          ovr_q, ovr_d;
   logic                last_q, last_d;
   logic                sel_q, sel_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                start_q, start_d;
   logic                rpd_q, rpd_d;
   logic                yd_q, yd_d;

   logic [1:0]          req;
   logic [1:0]          grant_mask;
   logic                pick;
   logic [CNT_BITS-1:0] run_n;

   // bit 0 = roll/pitch, bit 1 = yaw, matching the overrun encoding
   assign req = {bus.yaw_req, bus.rp_req};

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      ovr_d      = ovr_q;
      last_d     = last_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      start_d    = 1'b0;
      rpd_d      = 1'b0;
      yd_d       = 1'b0;
      grant_mask = 2'b00;
      pick       = 1'b0;
      run_n      = sel_q ? YAW_N : RP_N;

      case (state_q)
         S_IDLE: begin
            if (pend_q != 2'b00) begin
               // both pending: the axis not served last time wins
               pick       = (&pend_q) ? ~last_q : pend_q[1];
               grant_mask = pick ? 2'b10 : 2'b01;
               state_d    = S_RUN;
               last_d     = pick;
               sel_d      = pick;
               cnt_d      = CNT_BITS'(1);
               start_d    = 1'b1;
            end
         end
         S_RUN: begin
            if (cnt_q == run_n) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               rpd_d   = ~sel_q;
               yd_d    = sel_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A request for the axis being granted this cycle re-queues cleanly;
      // only a request hitting a pending bit that stays set is an overrun.
      ovr_d  = ovr_q | (req & pend_q & ~grant_mask);
      pend_d = (pend_q & ~grant_mask) | req;

      if (bus.clear) begin
         state_d = S_IDLE;
         pend_d  = 2'b00;
         ovr_d   = 2'b00;
         cnt_d   = '0;
         start_d = 1'b0;
         rpd_d   = 1'b0;
         yd_d    = 1'b0;
         last_d  = last_q;
         sel_d   = sel_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pend_q  <= 2'b00;
         ovr_q   <= 2'b00;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         cnt_q   <= '0;
         start_q <= 1'b0;
         rpd_q   <= 1'b0;
         yd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         rpd_q   <= rpd_d;
         yd_q    <= yd_d;
      end
   end

   assign bus.dp_start  = start_q;
   assign bus.dp_sel    = sel_q;
   assign bus.busy      = (state_q == S_RUN);
   assign bus.count_out = cnt_q;
   assign bus.rp_done   = rpd_q;
   assign bus.yaw_done  = yd_q;
   assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_kalman_scheduler.sv
// Bench for kalman_scheduler: directed scenarios plus random request traffic,
// every cycle compared against a time-stamp based reference model, with a few
// literal cycle-number expectations pinning the model itself.
module tb_kalman_scheduler;
   localparam int CNT_BITS = 6;
   localparam int RP_N     = 63;
   localparam int YAW_N    = 63;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   kalman_scheduler_if #(.CNT_BITS(CNT_BITS)) bus ();

   kalman_scheduler #(
      .CNT_BITS  (CNT_BITS),
      .RP_CYCLES (RP_N),
      .YAW_CYCLES(YAW_N)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model: a run is described by its grant edge and axis
   int       e      = 0;
   int       m_g    = 0;
   bit       m_busy = 1'b0;
   bit       m_axis = 1'b0;
   bit       m_last = 1'b1;
   bit [1:0] m_pend = 2'b00;
   bit [1:0] m_ovr  = 2'b00;
   bit       m_rpd  = 1'b0;
   bit       m_yd   = 1'b0;

   function automatic int n_of(bit a);
      return a ? YAW_N : RP_N;
   endfunction

   task automatic model(input bit r, input bit c, input bit rp, input bit yw);
      e++;
      m_rpd = 1'b0;
      m_yd  = 1'b0;
      if (r) begin
         m_busy = 1'b0; m_axis = 1'b0; m_last = 1'b1; m_pend = 2'b00; m_ovr = 2'b00;
      end else if (c) begin
         m_busy = 1'b0; m_pend = 2'b00; m_ovr = 2'b00;
      end else begin
         if (m_busy) begin
            if (e == m_g + n_of(m_axis)) begin
               m_busy = 1'b0;
               if (m_axis) m_yd = 1'b1; else m_rpd = 1'b1;
            end
         end else if (m_pend != 2'b00) begin
            automatic bit g = (m_pend == 2'b11) ? !m_last : m_pend[1];
            m_pend[g] = 1'b0;
            m_busy = 1'b1; m_axis = g; m_last = g; m_g = e;
         end
         if (rp) begin
            if (m_pend[0]) m_ovr[0] = 1'b1;
            m_pend[0] = 1'b1;
         end
         if (yw) begin
            if (m_pend[1]) m_ovr[1] = 1'b1;
            m_pend[1] = 1'b1;
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d t=%0t actual=%0d expected=%0d", name, cyc, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("dp_start",  int'(bus.dp_start),  int'(m_busy && e == m_g));
      chk("dp_sel",    int'(bus.dp_sel),    int'(m_axis));
      chk("busy",      int'(bus.busy),      int'(m_busy));
      chk("count_out", int'(bus.count_out), m_busy ? (e - m_g + 1) : 0);
      chk("rp_done",   int'(bus.rp_done),   int'(m_rpd));
      chk("yaw_done",  int'(bus.yaw_done),  int'(m_yd));
      chk("overrun",   int'(bus.overrun),   int'(m_ovr));
   endtask

   task automatic step(input bit r, input bit c, input bit rp, input bit yw);
      rst         = r;
      bus.clear   = c;
      bus.rp_req  = rp;
      bus.yaw_req = yw;
      @(posedge clk);
      model(r, c, rp, yw);
      #1;
      compare_all();
      cyc++;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      cyc = 0;
   endtask

   initial begin
      bus.clear   = 1'b0;
      bus.rp_req  = 1'b0;
      bus.yaw_req = 1'b0;

      // 1: single roll/pitch run with default budget
      do_reset();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_count", int'(bus.count_out), 0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      while (cyc <= 70) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         case (cyc)
            1:  chk("t1_no_start_c1", int'(bus.dp_start), 0);
            2:  begin chk("t1_start_c2", int'(bus.dp_start), 1); chk("t1_sel_c2", int'(bus.dp_sel), 0); end
            3:  chk("t1_start_c3", int'(bus.dp_start), 0);
            64: begin chk("t1_busy_c64", int'(bus.busy), 1); chk("t1_cnt_c64", int'(bus.count_out), 63); end
            65: begin chk("t1_done_c65", int'(bus.rp_done), 1); chk("t1_busy_c65", int'(bus.busy), 0); end
            66: chk("t1_done_c66", int'(bus.rp_done), 0);
            default: ;
         endcase
      end

      // 2: simultaneous requests after reset, roll/pitch first
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b1);
      while (cyc <= 131) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         case (cyc)
            65:  chk("t2_rp_done_c65", int'(bus.rp_done), 1);
            66:  begin chk("t2_ystart_c66", int'(bus.dp_start), 1); chk("t2_sel_c66", int'(bus.dp_sel), 1); end
            129: chk("t2_ydone_c129", int'(bus.yaw_done), 1);
            default: ;
         endcase
      end

      // 3: round-robin when both queue during a roll/pitch run
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      while (cyc <= 195) begin
         step(1'b0, 1'b0, cyc == 10, cyc == 12);
         case (cyc)
            66:  chk("t3_sel_yaw_c66", int'(bus.dp_sel), 1);
            130: begin chk("t3_start_c130", int'(bus.dp_start), 1); chk("t3_sel_rp_c130", int'(bus.dp_sel), 0); end
            193: chk("t3_rp_done_c193", int'(bus.rp_done), 1);
            default: ;
         endcase
      end

      // 4: duplicate roll/pitch request during a yaw run
      do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      while (cyc <= 135) begin
         step(1'b0, 1'b0, cyc == 10 || cyc == 20, 1'b0);
         case (cyc)
            20:  chk("t4_ovr_c20", int'(bus.overrun), 0);
            21:  chk("t4_ovr_c21", int'(bus.overrun), 1);
            66:  begin chk("t4_start_c66", int'(bus.dp_start), 1); chk("t4_sel_c66", int'(bus.dp_sel), 0); end
            129: chk("t4_rp_done_c129", int'(bus.rp_done), 1);
            132: begin chk("t4_idle_c132", int'(bus.busy), 0); chk("t4_ovr_c132", int'(bus.overrun), 1); end
            default: ;
         endcase
      end

      // 5: clear at count_out=20 drops run, queue and overrun
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      while (cyc <= 90) begin
         step(1'b0, cyc == 21, cyc == 5 || cyc == 8 || cyc == 80, cyc == 21);
         case (cyc)
            21: chk("t5_cnt_c21", int'(bus.count_out), 20);
            22: begin
               chk("t5_busy_c22", int'(bus.busy), 0);
               chk("t5_cnt_c22", int'(bus.count_out), 0);
               chk("t5_ovr_c22", int'(bus.overrun), 0);
            end
            24: chk("t5_no_restart_c24", int'(bus.busy), 0);
            82: chk("t5_start_c82", int'(bus.dp_start), 1);
            default: ;
         endcase
      end

      // 6: reset mid-run together with yaw request
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      while (cyc <= 20) begin
         step(cyc == 10, 1'b0, cyc == 12, cyc == 10 || cyc == 12);
         case (cyc)
            11: begin chk("t6_busy_c11", int'(bus.busy), 0); chk("t6_cnt_c11", int'(bus.count_out), 0); end
            13: chk("t6_idle_c13", int'(bus.busy), 0);
            14: begin chk("t6_start_c14", int'(bus.dp_start), 1); chk("t6_sel_c14", int'(bus.dp_sel), 0); end
            default: ;
         endcase
      end

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 999) == 0, $urandom_range(0, 299) == 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/kalman_scheduler.md
Name: kalman_scheduler

Overview:
- Arbitrates between roll/pitch and yaw update requests and time-shares the single Kalman compute datapath between them.
- For each granted request: issues a one-cycle start strobe, drives the axis select, times a fixed per-axis cycle budget with an internal counter, then pulses a per-axis done.
- Sits between the sensor-sample front end (requesters) and the Kalman datapath; replaces ad-hoc per-axis enables with queued, fair sequencing.

Parameters:
- CNT_BITS, 6, width of the internal cycle counter and of count_out.
- RP_CYCLES, 63, datapath cycles per roll/pitch update. Legal range 1..2^CNT_BITS-1.
- YAW_CYCLES, 63, datapath cycles per yaw update. Same legal range.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort: drops the current run and all queued work.
- rp_req  input  1  single-cycle roll/pitch update request pulse.
- yaw_req  input  1  single-cycle yaw update request pulse.
- dp_start  output  1  one-cycle start strobe to the datapath.
- dp_sel  output  1  datapath axis select: 0 = roll/pitch, 1 = yaw.
- busy  output  1  high while a run is in progress.
- count_out  output  CNT_BITS  current cycle index within the run.
- rp_done  output  1  one-cycle pulse when a roll/pitch run completes.
- yaw_done  output  1  one-cycle pulse when a yaw run completes.
- overrun  output  2  sticky error bits: [0] roll/pitch, [1] yaw.

Interface (decided): one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, pending=00, last_grant=yaw.
  - Outputs after reset: dp_start=0, dp_sel=0, busy=0, count_out=0, rp_done=0, yaw_done=0, overrun=00.
  - rst overrides every other input.
- Request capture:
  - A req pulse sets its pending bit at the next edge.
  - A req arriving while its pending bit is already 1 and not being cleared that cycle sets the matching overrun bit. Overrun bits are sticky until rst or clear. The duplicate request is merged, not queued twice.
  - A req in the same cycle as the grant of that axis leaves the pending bit set (new request queued) and does not flag overrun.
  - Requests arriving during RUN queue normally.
- States:
  - IDLE: busy=0, count_out=0.
    - If exactly one pending bit is set, grant that axis.
    - If both are set, grant the axis opposite last_grant (round-robin). After reset roll/pitch wins first.
    - On grant (at the edge): state→RUN, clear that pending bit, update last_grant and dp_sel, count_out←1, dp_start←1.
  - RUN: busy=1.
    - dp_start is high only in the first RUN cycle.
    - count_out increments by 1 per cycle, taking values 1..N (N = RP_CYCLES or YAW_CYCLES for dp_sel).
    - In the cycle where count_out==N, the next edge moves to IDLE and asserts the done pulse for dp_sel in that first IDLE cycle.
- Latency:
  - req at cycle c → pending at c+1 → dp_start at c+2.
  - Run occupies cycles c+2..c+N+1. Done pulses at c+N+2.
- Back-to-back runs:
  - The done cycle is an IDLE cycle and may grant, so the next dp_start comes exactly one cycle after done.
  - Minimum gap between runs: one IDLE cycle.
- dp_sel holds the last granted axis while IDLE.
- clear (sync, priority below rst, above everything else):
  - Next state IDLE; pending←00, overrun←00, count_out←0.
  - No done pulse is issued and dp_start is 0.
  - Requests presented in the same cycle are dropped. dp_sel and last_grant are retained.
- The counter never wraps: N is at most 2^CNT_BITS-1. Parameter values outside 1..2^CNT_BITS-1 are illegal and are flagged by an elaboration-time check.

Test Plan:
1. Reset, then rp_req pulse at cycle 0 (defaults) → dp_start=1 at cycle 2 only, dp_sel=0; busy 2..64; count_out 1..63; rp_done=1 at cycle 65 only; overrun=00.
2. rp_req and yaw_req in the same cycle 0 after reset → roll/pitch granted first (rp_done at 65); yaw dp_start at 66 with dp_sel=1; yaw_done at 129.
3. Round-robin: during a roll/pitch run, pulse rp_req then yaw_req → on completion yaw is granted first, then roll/pitch. Both pending with last_grant=yaw → roll/pitch is granted.
4. Overrun: during a yaw run, pulse rp_req twice (cycles apart) → overrun=01 immediately after the second pulse; exactly one roll/pitch run follows; overrun stays 01 across the run.
5. clear when count_out=20 → next cycle busy=0, count_out=0, pending=00, overrun=00; no done pulse; a later rp_req starts normally with 2-cycle latency.
6. rst asserted mid-run together with yaw_req → all outputs at reset values next cycle; no run starts; the next grant favours roll/pitch.
